// File: rtl/mac_pkg.sv
// mac_pkg: shared state type, frame constants and CRC helper for mac_frame_gen
// The FCS state exists only when MAC_FRAME_GEN_FCS_EN is defined.
package mac_pkg;
  localparam int HDR_BYTES = 14;
  localparam int FCS_BYTES = 4;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
`ifdef MAC_FRAME_GEN_FCS_EN
  typedef enum logic [2:0] {IDLE, HDR, PAY, FCS, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, PAY, GAP} state_t;
`endif
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction
endpackage

// File: rtl/mac_crc32_d8.sv
// mac_crc32_d8: one byte step of reflected IEEE 802.3 CRC-32 (built only with MAC_FRAME_GEN_FCS_EN)
// Ports: crc_in running register, data next byte, crc_out updated register.
`ifdef MAC_FRAME_GEN_FCS_EN
module mac_crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ POLY_R : crc_out >> 1;
  end
endmodule
`endif

// File: rtl/mac_frame_gen.sv
// mac_frame_gen: Ethernet frame generator (header, seeded/padded payload, optional FCS) onto a byte AXI-stream
// Ports: tx_fifo_aclk clock, tx_fifo_reset async active-high reset; start + dst_mac/src_mac/ethertype/payload_len/seed
// request a frame; tx_axis_fifo_* byte stream; busy until the inter-frame gap ends; done on tlast acceptance;
// frame_cnt counts completed frames. Define MAC_FRAME_GEN_FCS_EN to append a CRC-32 FCS.
module mac_frame_gen
  import mac_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46
) (
  input  logic        tx_fifo_aclk,
  input  logic        tx_fifo_reset,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [10:0] payload_len,
  input  logic [7:0]  seed,
  output logic [7:0]  tx_axis_fifo_tdata,
  output logic        tx_axis_fifo_tvalid,
  output logic        tx_axis_fifo_tlast,
  input  logic        tx_axis_fifo_tready,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt
);
`ifdef MAC_FRAME_GEN_FCS_EN
  localparam logic LAST_IN_PAY = 1'b0;
  logic [31:0] crc_q, crc_nxt, fcs;
  logic last_pay;
  mac_crc32_d8 u_crc (.crc_in(crc_q), .data(tx_axis_fifo_tdata), .crc_out(crc_nxt));
`else
  localparam logic LAST_IN_PAY = 1'b1;
`endif
  state_t state;
  logic [103:0] hdr;
  logic [10:0] cnt, nxt_idx, len_req, len_eff, len_clamp;
  logic [7:0] seed_r, pay_byte;
  logic [15:0] gap_cnt;
  logic accept;
  assign accept = tx_axis_fifo_tvalid & tx_axis_fifo_tready;
  assign done = accept & tx_axis_fifo_tlast;
  assign nxt_idx = cnt + 11'd1;
  always_comb begin
    len_clamp = payload_len > 11'(MAX_PAYLOAD) ? 11'(MAX_PAYLOAD) : payload_len;
    len_clamp = len_clamp < 11'(MIN_PAYLOAD) ? 11'(MIN_PAYLOAD) : len_clamp;
    pay_byte = nxt_idx < len_req ? seed_r + nxt_idx[7:0] : 8'h00;
  end
`ifdef MAC_FRAME_GEN_FCS_EN
  assign last_pay = cnt == len_eff - 11'd1;
  always_ff @(posedge tx_fifo_aclk or posedge tx_fifo_reset)
    if (tx_fifo_reset) crc_q <= '1;
    else if (state == IDLE) crc_q <= '1;
    else if (accept && (state == HDR || state == PAY)) crc_q <= crc_nxt;
`endif
  always_ff @(posedge tx_fifo_aclk or posedge tx_fifo_reset)
    if (tx_fifo_reset) begin
      state <= IDLE;
      hdr <= '0;
      cnt <= '0;
      len_req <= '0;
      len_eff <= '0;
      seed_r <= '0;
      gap_cnt <= '0;
      busy <= 1'b0;
      frame_cnt <= '0;
      tx_axis_fifo_tdata <= '0;
      tx_axis_fifo_tvalid <= 1'b0;
      tx_axis_fifo_tlast <= 1'b0;
`ifdef MAC_FRAME_GEN_FCS_EN
      fcs <= '0;
`endif
    end else if (done) begin
      state <= IFG_CYCLES == 0 ? IDLE : GAP;
      busy <= IFG_CYCLES != 0;
      gap_cnt <= 16'(IFG_CYCLES - 1);
      frame_cnt <= frame_cnt + 16'd1;
      tx_axis_fifo_tdata <= '0;
      tx_axis_fifo_tvalid <= 1'b0;
      tx_axis_fifo_tlast <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= HDR;
          busy <= 1'b1;
          cnt <= '0;
          hdr <= {dst_mac[39:0], src_mac, ethertype};
          len_req <= payload_len;
          len_eff <= len_clamp;
          seed_r <= seed;
          tx_axis_fifo_tdata <= dst_mac[47:40];
          tx_axis_fifo_tvalid <= 1'b1;
          tx_axis_fifo_tlast <= 1'b0;
        end
        HDR: if (accept) begin
          if (cnt == 11'(HDR_BYTES - 1)) begin
            state <= PAY;
            cnt <= '0;
            tx_axis_fifo_tdata <= len_req != 11'd0 ? seed_r : 8'h00;
            tx_axis_fifo_tlast <= LAST_IN_PAY && len_eff == 11'd1;
          end else begin
            cnt <= nxt_idx;
            tx_axis_fifo_tdata <= hdr[103:96];
            hdr <= hdr << 8;
          end
        end
        PAY: if (accept) begin
`ifdef MAC_FRAME_GEN_FCS_EN
          if (last_pay) begin
            state <= FCS;
            cnt <= '0;
            fcs <= ~crc_nxt;
            tx_axis_fifo_tdata <= ~crc_nxt[7:0];
          end else
`endif
          begin
            cnt <= nxt_idx;
            tx_axis_fifo_tdata <= pay_byte;
            tx_axis_fifo_tlast <= LAST_IN_PAY && nxt_idx == len_eff - 11'd1;
          end
        end
`ifdef MAC_FRAME_GEN_FCS_EN
        FCS: if (accept) begin
          cnt <= nxt_idx;
          fcs <= fcs >> 8;
          tx_axis_fifo_tdata <= fcs[15:8];
          tx_axis_fifo_tlast <= nxt_idx == 11'(FCS_BYTES - 1);
        end
`endif
        GAP: if (gap_cnt == 16'd0) begin
          state <= IDLE;
          busy <= 1'b0;
        end else gap_cnt <= gap_cnt - 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule
